// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: accepts one branch at a time and waits out any in-flight
// flag-writing op. It evaluates the condition against {N,V,Z} sampled once,
// emits a one-cycle resolution and, for taken branches, holds a fixed-length
// flush window toward fetch/decode.
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic             br_is_reg,
    input  logic [2:0]       br_cond,
    input  logic [8:0]       br_imm9,
    input  logic [15:0]      br_pc_plus2,
    input  logic [15:0]      br_rs_data,
    input  logic [2:0]       flag_in,
    input  logic             flag_busy,
    output logic             resolve_valid,
    output logic             br_taken,
    output logic [15:0]      redirect_pc,
    output logic             stall,
    output logic             flush,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {IDLE, WAIT, RESOLVE, FLUSH} state_t;

    // The flush counter must still be at least one bit wide when the window is disabled.
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    state_t          state;
    logic [FC_W-1:0] flush_cnt;

    // Branch fields held while the branch waits for flags to settle.
    logic            is_reg_q;
    logic [2:0]      cond_q;
    logic [8:0]      imm_q;
    logic [15:0]     pc_q;
    logic [15:0]     rs_q;

    logic            cur_is_reg;
    logic [2:0]      cur_cond;
    logic [8:0]      cur_imm;
    logic [15:0]     cur_pc;
    logic [15:0]     cur_rs;
    logic            cond_hit;
    logic [15:0]     target;
    logic [15:0]     next_pc;

    // Condition table over flags ordered {N,V,Z}.
    function automatic logic cond_eval(input logic [2:0] cond, input logic [2:0] nvz);
        logic n, v, z;
        {n, v, z} = nvz;
        case (cond)
            3'b000:  return !z;
            3'b001:  return z;
            3'b010:  return !z && !n;
            3'b011:  return n;
            3'b100:  return z || (!z && !n);
            3'b101:  return n || z;
            3'b110:  return v;
            default: return 1'b1;
        endcase
    endfunction

    // Resolve from the incoming branch when capturing straight out of IDLE,
    // otherwise from the fields latched at acceptance.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path so no latch is inferred.
        cur_is_reg = is_reg_q;
        cur_cond   = cond_q;
        cur_imm    = imm_q;
        cur_pc     = pc_q;
        cur_rs     = rs_q;
        if (state == IDLE) begin
            cur_is_reg = br_is_reg;
            cur_cond   = br_cond;
            cur_imm    = br_imm9;
            cur_pc     = br_pc_plus2;
            cur_rs     = br_rs_data;
        end
        cond_hit = cond_eval(cur_cond, flag_in);
        target   = cur_is_reg ? cur_rs
                              : cur_pc + {{6{cur_imm[8]}}, cur_imm, 1'b0};
        next_pc  = cond_hit ? target : cur_pc;
    end

    // Control FSM with all handshake and resolution outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
            state         <= IDLE;
            flush_cnt     <= '0;
            is_reg_q      <= 1'b0;
            cond_q        <= '0;
            imm_q         <= '0;
            pc_q          <= '0;
            rs_q          <= '0;
            br_ready      <= 1'b1;
            resolve_valid <= 1'b0;
            br_taken      <= 1'b0;
            redirect_pc   <= '0;
            stall         <= 1'b0;
            flush         <= 1'b0;
            taken_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (br_valid) begin
                        is_reg_q <= br_is_reg;
                        cond_q   <= br_cond;
                        imm_q    <= br_imm9;
                        pc_q     <= br_pc_plus2;
                        rs_q     <= br_rs_data;
                        br_ready <= 1'b0;
                        stall    <= 1'b1;
                        if (flag_busy) begin
                            state <= WAIT;
                        end else begin
                            state         <= RESOLVE;
                            resolve_valid <= 1'b1;
                            br_taken      <= cond_hit;
                            redirect_pc   <= next_pc;
                        end
                    end
                end
                WAIT: begin
                    if (!flag_busy) begin
                        state         <= RESOLVE;
                        resolve_valid <= 1'b1;
                        br_taken      <= cond_hit;
                        redirect_pc   <= next_pc;
                    end
                end
                RESOLVE: begin
                    resolve_valid <= 1'b0;
                    if (br_taken && taken_count != '1)
                        taken_count <= taken_count + CNT_W'(1);
                    if (br_taken && FLUSH_CYCLES > 0) begin
                        state     <= FLUSH;
                        flush     <= 1'b1;
                        flush_cnt <= '0;
                    end else begin
                        state    <= IDLE;
                        stall    <= 1'b0;
                        br_ready <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FC_LAST) begin
                        state    <= IDLE;
                        flush    <= 1'b0;
                        stall    <= 1'b0;
                        br_ready <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + FC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected resolutions are queued
// when a branch is offered and compared when resolve_valid appears.
module tb_branch_resolve_unit;

    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             br_valid;
    logic             br_ready;
    logic             br_is_reg;
    logic [2:0]       br_cond;
    logic [8:0]       br_imm9;
    logic [15:0]      br_pc_plus2;
    logic [15:0]      br_rs_data;
    logic [2:0]       flag_in;
    logic             flag_busy;
    logic             resolve_valid;
    logic             br_taken;
    logic [15:0]      redirect_pc;
    logic             stall;
    logic             flush;
    logic [CNT_W-1:0] taken_count;

    typedef struct packed {
        logic        taken;
        logic [15:0] pc;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    branch_resolve_unit #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .br_valid(br_valid), .br_ready(br_ready),
        .br_is_reg(br_is_reg), .br_cond(br_cond), .br_imm9(br_imm9),
        .br_pc_plus2(br_pc_plus2), .br_rs_data(br_rs_data),
        .flag_in(flag_in), .flag_busy(flag_busy),
        .resolve_valid(resolve_valid), .br_taken(br_taken),
        .redirect_pc(redirect_pc), .stall(stall), .flush(flush),
        .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference condition table, flags {N,V,Z}.
    function automatic logic model_taken(input logic [2:0] cond, input logic [2:0] f);
        logic n, v, z;
        n = f[2]; v = f[1]; z = f[0];
        case (cond)
            3'd0: model_taken = (z == 1'b0);
            3'd1: model_taken = (z == 1'b1);
            3'd2: model_taken = (z == 1'b0) && (n == 1'b0);
            3'd3: model_taken = (n == 1'b1);
            3'd4: model_taken = (z == 1'b1) || ((z == 1'b0) && (n == 1'b0));
            3'd5: model_taken = (n == 1'b1) || (z == 1'b1);
            3'd6: model_taken = (v == 1'b1);
            default: model_taken = 1'b1;
        endcase
    endfunction

    function automatic res_t model(input logic is_reg, input logic [2:0] cond, input logic [8:0] imm,
                                   input logic [15:0] pc, input logic [15:0] rs, input logic [2:0] f);
        res_t r;
        int   off;
        off     = $signed(imm);
        r.taken = model_taken(cond, f);
        if (!r.taken)    r.pc = pc;
        else if (is_reg) r.pc = rs;
        else             r.pc = 16'(int'(pc) + off * 2);
        return r;
    endfunction

    // Scoreboard side: compare each resolution against the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && resolve_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_resolve", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("br_taken", 32'(br_taken), 32'(e.taken));
                check("redirect_pc", 32'(redirect_pc), 32'(e.pc));
                check("count_before", 32'(taken_count), 32'(exp_cnt));
                if (e.taken && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
            end
        end
    end

    // Offer a branch; busy_cycles>0 holds flag_busy so the unit sits that many cycles in WAIT.
    // Returns just after the capture edge.
    task automatic offer(input logic is_reg, input logic [2:0] cond, input logic [8:0] imm,
                         input logic [15:0] pc, input logic [15:0] rs, input logic [2:0] f,
                         input int busy_cycles, input logic [2:0] f_busy);
        int n;
        n = 0;
        @(negedge clk);
        while (br_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (br_ready !== 1'b1) check("ready_timeout", 32'(br_ready), 32'd1);
        br_valid    = 1'b1;
        br_is_reg   = is_reg;
        br_cond     = cond;
        br_imm9     = imm;
        br_pc_plus2 = pc;
        br_rs_data  = rs;
        flag_busy   = (busy_cycles > 0);
        flag_in     = (busy_cycles > 0) ? f_busy : f;
        exp_q.push_back(model(is_reg, cond, imm, pc, rs, f));
        @(posedge clk);
        #1;
        br_valid    = 1'b0;
        br_cond     = ~cond;
        br_rs_data  = ~rs;
        for (int i = 0; i < busy_cycles; i++) begin
            @(negedge clk);
            check("wait_stall", 32'(stall), 32'd1);
            check("wait_no_resolve", 32'(resolve_valid), 32'd0);
            if (i == busy_cycles - 1) begin
                flag_busy = 1'b0;
                flag_in   = f;
            end
        end
        if (busy_cycles > 0) begin
            @(posedge clk);
            #1;
        end
        // Flags move after capture; the branch in flight must ignore them.
        flag_in   = ~f;
        flag_busy = 1'b1;
    endtask

    // Check resolve latency, flush window length and return to IDLE.
    task automatic finish(input logic taken);
        @(negedge clk);
        check("resolve_latency", 32'(resolve_valid), 32'd1);
        check("resolve_ready", 32'(br_ready), 32'd0);
        if (taken) begin
            for (int i = 0; i < FLUSH_CYCLES; i++) begin
                @(negedge clk);
                check("flush_hi", 32'(flush), 32'd1);
                check("flush_stall", 32'(stall), 32'd1);
            end
        end
        @(negedge clk);
        check("flush_lo", 32'(flush), 32'd0);
        check("ready_back", 32'(br_ready), 32'd1);
        check("stall_lo", 32'(stall), 32'd0);
        flag_busy = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(br_ready), 32'd1);
        check({tag, "_rv"}, 32'(resolve_valid), 32'd0);
        check({tag, "_taken"}, 32'(br_taken), 32'd0);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_flush"}, 32'(flush), 32'd0);
        check({tag, "_pc"}, 32'(redirect_pc), 32'd0);
        check({tag, "_cnt"}, 32'(taken_count), 32'd0);
    endtask

    initial begin
        logic [15:0] pc;
        logic [8:0]  imm;
        res_t        e;
        rst = 1'b0; br_valid = 1'b0; br_is_reg = 1'b0; br_cond = '0; br_imm9 = '0;
        br_pc_plus2 = '0; br_rs_data = '0; flag_in = '0; flag_busy = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // B EQ with Z=1: taken to 0x0018.
        offer(1'b0, 3'b001, 9'h004, 16'h0010, 16'h0000, 3'b001, 0, 3'b000);
        finish(1'b1);
        check("count_after_first", 32'(taken_count), 32'd1);

        // B LT behind three busy cycles; N=1 only at release, negative offset.
        offer(1'b0, 3'b011, 9'h1FE, 16'h0010, 16'h0000, 3'b100, 3, 3'b000);
        finish(1'b1);

        // BR NE with Z=1: not taken, falls through.
        offer(1'b1, 3'b000, 9'h000, 16'h0042, 16'hBEEF, 3'b001, 0, 3'b000);
        finish(1'b0);
        check("hold_taken", 32'(br_taken), 32'd0);
        check("hold_pc", 32'(redirect_pc), 32'h0042);

        // BR UN: taken to the register target.
        offer(1'b1, 3'b111, 9'h000, 16'h0042, 16'hBEEF, 3'b000, 1, 3'b111);
        finish(1'b1);

        // Wrap past 0xFFFF.
        offer(1'b0, 3'b111, 9'h0FF, 16'hFFFE, 16'h0000, 3'b000, 0, 3'b000);
        finish(1'b1);

        // All conditions against all flag values.
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                pc  = 16'($urandom);
                imm = 9'($urandom);
                e   = model(1'b0, 3'(c), imm, pc, 16'h0, 3'(f));
                offer(1'b0, 3'(c), imm, pc, 16'h0, 3'(f), f % 3, 3'($urandom));
                finish(e.taken);
            end
        end
        check("count_saturated", 32'(taken_count), 32'hF);

        // Reset mid-WAIT: the aborted branch never resolves.
        @(negedge clk);
        br_valid = 1'b1; br_is_reg = 1'b0; br_cond = 3'b111; flag_busy = 1'b1;
        @(posedge clk);
        #1 br_valid = 1'b0;
        @(negedge clk);
        check("midwait_stall", 32'(stall), 32'd1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("rst_wait");
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b1; flag_busy = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_wait_idle", 32'(br_ready), 32'd1);

        // Reset mid-FLUSH.
        offer(1'b0, 3'b111, 9'h010, 16'h0100, 16'h0, 3'b000, 0, 3'b000);
        @(negedge clk);
        check("pre_flush_rv", 32'(resolve_valid), 32'd1);
        @(negedge clk);
        check("midflush_flush", 32'(flush), 32'd1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("rst_flush");
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b1; flag_busy = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_flush_idle", 32'(br_ready), 32'd1);
        check("rst_flush_noflush", 32'(flush), 32'd0);

        // Saturation: 15 taken fill the 4-bit counter, two more hold it.
        for (int i = 0; i < 17; i++) begin
            offer(1'b1, 3'b111, 9'h0, 16'h0002, 16'(i), 3'($urandom), 0, 3'b000);
            finish(1'b1);
            if (i == 14) check("count_15", 32'(taken_count), 32'hF);
        end
        check("count_hold", 32'(taken_count), 32'hF);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer of the N/V/Z flag register written by the ALU.
- Accepts one branch at a time (B with imm9, or BR with register target) and waits while a flag-writing instruction is still in flight.
- Evaluates the 3-bit condition against the captured flags, then emits a one-cycle resolution with taken/not-taken and next PC.
- On a taken branch it drives a fixed-length flush window toward fetch/decode.

Parameters:
- FLUSH_CYCLES, 2, cycles flush is held high after a taken branch (0 allowed = no flush window).
- CNT_W, 16, width of the saturating taken-branch counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- br_valid  in  1  branch offered this cycle.
- br_ready  out  1  unit can accept a branch (high only in IDLE).
- br_is_reg  in  1  1 = BR (target = br_rs_data), 0 = B (PC-relative).
- br_cond  in  3  condition code.
- br_imm9  in  9  signed word offset for B.
- br_pc_plus2  in  16  address of the instruction after the branch.
- br_rs_data  in  16  register target for BR.
- flag_in  in  3  current flag register value, order {N,V,Z}.
- flag_busy  in  1  a flag-writing op (ADD/SUB/XOR/SLL/SRA/ROR) has not yet updated flag_in.
- resolve_valid  out  1  one-cycle pulse: resolution outputs valid.
- br_taken  out  1  condition true (meaningful with resolve_valid).
- redirect_pc  out  16  next PC: target if taken, else br_pc_plus2.
- stall  out  1  high whenever state != IDLE.
- flush  out  1  high during the FLUSH window.
- taken_count  out  CNT_W  saturating count of taken branches.

Behaviour:
- Reset (rst=0, takes effect immediately, no clock needed):
  - State = IDLE, br_ready=1.
  - resolve_valid, br_taken, stall, flush = 0.
  - redirect_pc = 0, taken_count = 0, flush counter = 0.
  - Any branch in progress is discarded; no resolution is issued for it.
- Handshake:
  - A branch is accepted on a rising edge where br_valid & br_ready.
  - On acceptance, br_is_reg, br_cond, br_imm9, br_pc_plus2 and br_rs_data are registered.
  - br_valid while br_ready=0 is ignored; the upstream holds it.
- States IDLE, WAIT, RESOLVE, FLUSH:
  - IDLE, accept with flag_busy=0: capture flag_in, go to RESOLVE.
  - IDLE, accept with flag_busy=1: go to WAIT.
  - WAIT: stay while flag_busy=1. On the first edge with flag_busy=0, capture flag_in and go to RESOLVE.
  - RESOLVE: lasts exactly one cycle; resolve_valid=1, br_taken and redirect_pc are valid. Next state is FLUSH if taken and FLUSH_CYCLES>0, else IDLE.
  - FLUSH: flush=1 for exactly FLUSH_CYCLES cycles, then IDLE.
- Latency: accept at edge E with flag_busy=0 gives resolve_valid in the cycle after E. Each WAIT cycle adds one cycle.
- Throughput:
  - Not-taken branch: next accept one cycle after RESOLVE.
  - Taken branch: next accept after RESOLVE plus FLUSH_CYCLES cycles.
- Flags are sampled exactly once per branch, at the capture edge. Later flag_in or flag_busy changes (including during RESOLVE or FLUSH) do not affect that branch.
- Conditions (flags N,V,Z):
  - 000 NE: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 & N=0.
  - 011 LT: N=1.
  - 100 GE: Z=1 | (Z=0 & N=0).
  - 101 LE: N=1 | Z=1.
  - 110 OV: V=1.
  - 111 UN: always taken.
- Target computation:
  - B: br_pc_plus2 + (sign-extend(br_imm9) << 1), 16-bit modulo; wrap past FFFF or below 0000 is silent.
  - BR: br_rs_data unmodified.
- Outputs outside RESOLVE: br_taken and redirect_pc hold their last resolved values; resolve_valid=0.
- taken_count: increments in each RESOLVE cycle with br_taken=1; saturates at all-ones.
- stall is a registered/state-decoded output; flush is decoded from the FLUSH state.

Test Plan:
- B cond=001 (EQ), flag_in=3'b001, flag_busy=0, pc_plus2=0x0010, imm9=0x004 -> resolve_valid the cycle after accept, br_taken=1, redirect_pc=0x0018, flush high 2 cycles, taken_count=1, br_ready back high after flush.
- B cond=011 (LT), flag_busy=1 for 3 cycles; flag_in=3'b000 during busy, 3'b100 at release -> 3 WAIT cycles with stall=1, then taken using N=1. Negative offset: imm9=0x1FE, pc_plus2=0x0010 -> redirect_pc=0x000C.
- BR cond=000 (NE) with Z=1, rs=0xBEEF, pc_plus2=0x0042 -> br_taken=0, redirect_pc=0x0042, flush never asserts, br_ready high the next cycle.
- Sweep all 8 conditions over all 8 {N,V,Z} values -> br_taken matches the condition table. pc_plus2=0xFFFE, imm9=0x0FF -> redirect_pc wraps to 0x01FC.
- Drive rst low mid-WAIT and mid-FLUSH -> outputs clear immediately; no resolve_valid for the aborted branch; IDLE with br_ready=1 after release.
- Preload taken_count near saturation with CNT_W=4 (15 taken branches), then 2 more taken branches -> count holds at 0xF.
